// File: rtl/stepper_reg_bank_if.sv
// Host-side bus of the stepper configuration register bank.
// The master modport is the host/sequencer side; the slave modport is the bank.
interface stepper_reg_bank_if #(
    parameter int unsigned NUM_REGS = 30,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 7
);
    logic                         wr_en;
    logic                         wr_burst;
    logic [ADDR_W-1:0]            wr_addr;
    logic [DATA_W-1:0]            wr_data;
    logic                         commit;
    logic                         step_tick;
    logic                         rd_en;
    logic                         rd_sel;
    logic [ADDR_W-1:0]            rd_addr;
    logic                         err_clr;
    logic [DATA_W-1:0]            rd_data;
    logic                         rd_valid;
    logic [NUM_REGS*DATA_W-1:0]   active_regs;
    logic                         commit_pending;
    logic                         commit_done;
    logic                         err_addr;

    modport master (
        output wr_en, wr_burst, wr_addr, wr_data, commit, step_tick,
        output rd_en, rd_sel, rd_addr, err_clr,
        input  rd_data, rd_valid, active_regs, commit_pending, commit_done, err_addr
    );

    modport slave (
        input  wr_en, wr_burst, wr_addr, wr_data, commit, step_tick,
        input  rd_en, rd_sel, rd_addr, err_clr,
        output rd_data, rd_valid, active_regs, commit_pending, commit_done, err_addr
    );
endinterface

// File: rtl/stepper_reg_bank.sv
// Double-buffered stepper configuration bank: host writes fill the shadow bank and a
// commit copies it atomically into the active bank, optionally aligned to step_tick.
module stepper_reg_bank #(
    parameter int unsigned NUM_REGS    = 30,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned SYNC_COMMIT = 1
) (
    input logic               system1000,
    input logic               system1000_rst,
    stepper_reg_bank_if.slave bus
);

    localparam int unsigned      IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned      CMP_W  = ADDR_W + 1;
    localparam logic [CMP_W-1:0] LIMIT  = CMP_W'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    logic [DATA_W-1:0]          r_shadow [NUM_REGS];
    logic [DATA_W-1:0]          r_active [NUM_REGS];
    logic [ADDR_W-1:0]          r_ptr;
    logic [0:0]                 r_state;
    logic [DATA_W-1:0]          r_rd_data;
    logic                       r_rd_valid;
    logic                       r_commit_pending;
    logic                       r_commit_done;
    logic                       r_err_addr;

    logic [ADDR_W-1:0]          w_tgt;
    logic                       w_wr_ok;
    logic                       w_wr_err;
    logic [ADDR_W-1:0]          w_ptr_nxt;
    logic                       w_rd_ok;
    logic                       w_rd_err;
    logic [DATA_W-1:0]          w_rd_word;
    logic [0:0]                 w_state_nxt;
    logic                       w_copy;
    logic [NUM_REGS*DATA_W-1:0] w_flat;

    // Write target selection and range checks.
    always_comb begin
        w_tgt     = bus.wr_burst ? r_ptr : bus.wr_addr;
        w_wr_ok   = ({1'b0, w_tgt} < LIMIT);
        w_wr_err  = bus.wr_en & ~w_wr_ok;
        w_ptr_nxt = (w_tgt == LAST) ? '0 : w_tgt + ADDR_W'(1);
        w_rd_ok   = ({1'b0, bus.rd_addr} < LIMIT);
        w_rd_err  = bus.rd_en & ~w_rd_ok;
        w_rd_word = '0;
        if (w_rd_ok) begin
            w_rd_word = bus.rd_sel ? r_active[IDX_W'(bus.rd_addr)]
                                   : r_shadow[IDX_W'(bus.rd_addr)];
        end
    end

    // Commit sequencing: immediate, or deferred to the next step boundary.
    always_comb begin
        w_state_nxt = r_state;
        w_copy      = 1'b0;
        if (SYNC_COMMIT == 0) begin
            w_copy      = bus.commit;
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.commit) begin
                        if (bus.step_tick) begin
                            w_copy = 1'b1;
                        end else begin
                            w_state_nxt = ST_PEND;
                        end
                    end
                end
                ST_PEND: begin
                    if (bus.step_tick) begin
                        w_copy      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Both banks; the copy reads shadow before this cycle's write lands.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_shadow[IDX_W'(i)] <= '0;
                r_active[IDX_W'(i)] <= '0;
            end
            r_ptr <= '0;
        end else begin
            if (w_copy) begin
                for (int i = 0; i < int'(NUM_REGS); i++) begin
                    r_active[IDX_W'(i)] <= r_shadow[IDX_W'(i)];
                end
            end
            if (bus.wr_en && w_wr_ok) begin
                r_shadow[IDX_W'(w_tgt)] <= bus.wr_data;
                r_ptr                   <= w_ptr_nxt;
            end
        end
    end

    // Read port, status flags and commit handshake outputs.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            r_rd_data        <= '0;
            r_rd_valid       <= 1'b0;
            r_commit_pending <= 1'b0;
            r_commit_done    <= 1'b0;
            r_err_addr       <= 1'b0;
        end else begin
            r_rd_valid       <= bus.rd_en;
            r_rd_data        <= bus.rd_en ? w_rd_word : '0;
            r_commit_pending <= (w_state_nxt == ST_PEND);
            r_commit_done    <= w_copy;
            r_err_addr       <= w_wr_err | w_rd_err | (r_err_addr & ~bus.err_clr);
        end
    end

    // Register 0 occupies the most significant slice of the flat bus.
    for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_flat
        assign w_flat[(int'(NUM_REGS) - 1 - g)*int'(DATA_W) +: int'(DATA_W)] = r_active[g];
    end

    assign bus.active_regs    = w_flat;
    assign bus.rd_data        = r_rd_data;
    assign bus.rd_valid       = r_rd_valid;
    assign bus.commit_pending = r_commit_pending;
    assign bus.commit_done    = r_commit_done;
    assign bus.err_addr       = r_err_addr;

endmodule

// File: tb/tb_stepper_reg_bank.sv
// Scoreboard bench for stepper_reg_bank: one immediate-commit and one step-aligned
// instance, directed vectors, read responses checked by an independent monitor.
module tb_stepper_reg_bank;

    logic clk;
    logic rst;

    int n_vec;
    int n_bad;
    int dn_i;
    int dn_s;

    logic [7:0] q_i[$];
    logic [7:0] q_s[$];

    stepper_reg_bank_if #(.NUM_REGS(30), .DATA_W(8), .ADDR_W(7)) if_i ();
    stepper_reg_bank_if #(.NUM_REGS(30), .DATA_W(8), .ADDR_W(7)) if_s ();

    stepper_reg_bank #(.NUM_REGS(30), .DATA_W(8), .ADDR_W(7), .SYNC_COMMIT(0)) u_imm (
        .system1000     (clk),
        .system1000_rst (rst),
        .bus            (if_i)
    );

    stepper_reg_bank #(.NUM_REGS(30), .DATA_W(8), .ADDR_W(7), .SYNC_COMMIT(1)) u_sync (
        .system1000     (clk),
        .system1000_rst (rst),
        .bus            (if_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] act_i(input int r);
        return if_i.active_regs[(29 - r)*8 +: 8];
    endfunction

    function automatic logic [7:0] act_s(input int r);
        return if_s.active_regs[(29 - r)*8 +: 8];
    endfunction

    task automatic idle_all();
        if_i.wr_en = 0; if_i.wr_burst = 0; if_i.wr_addr = '0; if_i.wr_data = '0;
        if_i.commit = 0; if_i.step_tick = 0; if_i.rd_en = 0; if_i.rd_sel = 0;
        if_i.rd_addr = '0; if_i.err_clr = 0;
        if_s.wr_en = 0; if_s.wr_burst = 0; if_s.wr_addr = '0; if_s.wr_data = '0;
        if_s.commit = 0; if_s.step_tick = 0; if_s.rd_en = 0; if_s.rd_sel = 0;
        if_s.rd_addr = '0; if_s.err_clr = 0;
    endtask

    // One cycle of stimulus on instance d (0 = immediate, 1 = step-aligned).
    task automatic cyc(input int d, input logic we, input logic wb, input logic [6:0] wa,
                       input logic [7:0] wd, input logic cm, input logic st, input logic re,
                       input logic rs, input logic [6:0] ra, input logic [7:0] rexp,
                       input logic ec);
        if (d == 0) begin
            if_i.wr_en = we; if_i.wr_burst = wb; if_i.wr_addr = wa; if_i.wr_data = wd;
            if_i.commit = cm; if_i.step_tick = st; if_i.rd_en = re; if_i.rd_sel = rs;
            if_i.rd_addr = ra; if_i.err_clr = ec;
            if (re) q_i.push_back(rexp);
        end else begin
            if_s.wr_en = we; if_s.wr_burst = wb; if_s.wr_addr = wa; if_s.wr_data = wd;
            if_s.commit = cm; if_s.step_tick = st; if_s.rd_en = re; if_s.rd_sel = rs;
            if_s.rd_addr = ra; if_s.err_clr = ec;
            if (re) q_s.push_back(rexp);
        end
        @(posedge clk);
        #1;
        idle_all();
    endtask

    task automatic wr(input int d, input logic [6:0] a, input logic [7:0] v);
        cyc(d, 1, 0, a, v, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic bw(input int d, input logic [7:0] v);
        cyc(d, 1, 1, 0, v, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input int d, input logic s, input logic [6:0] a, input logic [7:0] e);
        cyc(d, 0, 0, 0, 0, 0, 0, 1, s, a, e, 0);
    endtask

    task automatic cm(input int d, input logic st);
        cyc(d, 0, 0, 0, 0, 1, st, 0, 0, 0, 0, 0);
    endtask

    task automatic nop(input int d, input logic st);
        cyc(d, 0, 0, 0, 0, 0, st, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: pops the expected read response whenever a bank presents rd_valid.
    always @(negedge clk) begin
        logic [7:0] e;
        if (if_i.rd_valid === 1'b1) begin
            if (q_i.size() == 0) begin
                chk("rd_i_unexpected", 256'(if_i.rd_data), 256'hx);
            end else begin
                e = q_i.pop_front();
                chk("rd_i", 256'(if_i.rd_data), 256'(e));
            end
        end
        if (if_s.rd_valid === 1'b1) begin
            if (q_s.size() == 0) begin
                chk("rd_s_unexpected", 256'(if_s.rd_data), 256'hx);
            end else begin
                e = q_s.pop_front();
                chk("rd_s", 256'(if_s.rd_data), 256'(e));
            end
        end
        if (if_i.commit_done === 1'b1) dn_i++;
        if (if_s.commit_done === 1'b1) dn_s++;
    end

    initial begin
        n_vec = 0; n_bad = 0; dn_i = 0; dn_s = 0;
        rst = 1'b1;
        idle_all();
        @(posedge clk);
        #1;
        do_reset();

        chk("rst_act_i", 256'(if_i.active_regs), 256'(0));
        chk("rst_act_s", 256'(if_s.active_regs), 256'(0));
        chk("rst_pend_s", 256'(if_s.commit_pending), 256'(0));
        chk("rst_done_i", 256'(if_i.commit_done), 256'(0));
        chk("rst_err_i", 256'(if_i.err_addr), 256'(0));
        chk("rst_rv_i", 256'(if_i.rd_valid), 256'(0));
        chk("rst_rd_data_i", 256'(if_i.rd_data), 256'(0));

        // Immediate commit of two single writes.
        wr(0, 7'd0, 8'h11);
        wr(0, 7'd29, 8'hA5);
        cm(0, 0);
        chk("imm_done_hi", 256'(if_i.commit_done), 256'(1));
        chk("imm_reg0", 256'(if_i.active_regs[239:232]), 256'(8'h11));
        chk("imm_reg29", 256'(if_i.active_regs[7:0]), 256'(8'hA5));
        chk("imm_pend_lo", 256'(if_i.commit_pending), 256'(0));
        nop(0, 0);
        chk("imm_done_lo", 256'(if_i.commit_done), 256'(0));

        // Burst writes following a single write, then a wrapping burst.
        wr(0, 7'd5, 8'h01);
        bw(0, 8'h02);
        bw(0, 8'h03);
        rd(0, 0, 7'd6, 8'h02);
        rd(0, 0, 7'd7, 8'h03);
        rd(0, 0, 7'd5, 8'h01);
        wr(0, 7'd28, 8'h66);
        bw(0, 8'h77);
        bw(0, 8'h88);
        rd(0, 0, 7'd29, 8'h77);
        rd(0, 0, 7'd0, 8'h88);
        rd(0, 0, 7'd28, 8'h66);
        rd(0, 1, 7'd0, 8'h11);

        // Out-of-range accesses and the sticky error flag.
        wr(0, 7'd30, 8'hEE);
        chk("err_bad_wr", 256'(if_i.err_addr), 256'(1));
        bw(0, 8'h99);
        rd(0, 0, 7'd1, 8'h99);
        rd(0, 0, 7'd31, 8'h00);
        chk("err_bad_rd", 256'(if_i.err_addr), 256'(1));
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("err_clr", 256'(if_i.err_addr), 256'(0));
        rd(0, 1, 7'd31, 8'h00);
        chk("err_rd_set", 256'(if_i.err_addr), 256'(1));
        cyc(0, 1, 0, 7'd127, 8'h55, 0, 0, 0, 0, 0, 0, 1);
        chk("err_set_wins", 256'(if_i.err_addr), 256'(1));
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("err_clr2", 256'(if_i.err_addr), 256'(0));

        // Same-cycle write and commit: active gets the pre-write shadow.
        wr(0, 7'd2, 8'h3C);
        cm(0, 0);
        chk("sc_done1", 256'(if_i.commit_done), 256'(1));
        cyc(0, 1, 0, 7'd2, 8'hFF, 1, 0, 0, 0, 0, 0, 0);
        chk("sc_done2", 256'(if_i.commit_done), 256'(1));
        chk("sc_act_reg2_old", 256'(act_i(2)), 256'(8'h3C));
        chk("sc_act_reg1", 256'(act_i(1)), 256'(8'h99));
        chk("sc_act_reg0", 256'(act_i(0)), 256'(8'h88));
        rd(0, 0, 7'd2, 8'hFF);
        rd(0, 1, 7'd2, 8'h3C);
        cm(0, 0);
        chk("sc_act_reg2_new", 256'(act_i(2)), 256'(8'hFF));
        nop(0, 0);
        chk("imm_done_count", 256'(dn_i), 256'(4));

        // Step-aligned bank: commit together with step_tick copies at once.
        wr(1, 7'd4, 8'h44);
        chk("sync_idle_act", 256'(act_s(4)), 256'(0));
        cm(1, 1);
        chk("sync_now_done", 256'(if_s.commit_done), 256'(1));
        chk("sync_now_pend", 256'(if_s.commit_pending), 256'(0));
        chk("sync_now_reg4", 256'(act_s(4)), 256'(8'h44));
        nop(1, 0);
        chk("sync_now_done_lo", 256'(if_s.commit_done), 256'(0));
        nop(1, 1);
        chk("sync_lone_tick", 256'(if_s.commit_done), 256'(0));

        // Deferred commit with a write and a repeated commit while pending.
        cm(1, 0);
        chk("pend_c1", 256'(if_s.commit_pending), 256'(1));
        chk("pend_c1_done", 256'(if_s.commit_done), 256'(0));
        nop(1, 0);
        chk("pend_c2", 256'(if_s.commit_pending), 256'(1));
        wr(1, 7'd3, 8'h5A);
        chk("pend_c3", 256'(if_s.commit_pending), 256'(1));
        chk("pend_reg3_old", 256'(act_s(3)), 256'(0));
        cm(1, 0);
        chk("pend_c4", 256'(if_s.commit_pending), 256'(1));
        nop(1, 0);
        chk("pend_c5", 256'(if_s.commit_pending), 256'(1));
        chk("pend_c5_done", 256'(if_s.commit_done), 256'(0));
        nop(1, 1);
        chk("pend_done", 256'(if_s.commit_done), 256'(1));
        chk("pend_cleared", 256'(if_s.commit_pending), 256'(0));
        chk("pend_reg3_new", 256'(act_s(3)), 256'(8'h5A));
        rd(1, 1, 7'd3, 8'h5A);
        chk("pend_done_lo", 256'(if_s.commit_done), 256'(0));
        chk("sync_done_count", 256'(dn_s), 256'(2));

        // Reset while a commit is pending drops it.
        wr(1, 7'd7, 8'h70);
        cm(1, 0);
        chk("rp_pend", 256'(if_s.commit_pending), 256'(1));
        do_reset();
        chk("rp_pend_clr", 256'(if_s.commit_pending), 256'(0));
        chk("rp_act_zero", 256'(if_s.active_regs), 256'(0));
        nop(1, 1);
        chk("rp_no_done", 256'(if_s.commit_done), 256'(0));
        chk("rp_act_still_zero", 256'(if_s.active_regs), 256'(0));
        nop(1, 0);
        chk("rp_no_done2", 256'(if_s.commit_done), 256'(0));

        chk("q_i_drained", 256'(q_i.size()), 256'(0));
        chk("q_s_drained", 256'(q_s.size()), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
